// File: rtl/buffer_pkg.sv
// Shared types and helpers for the scratchpad buffer controller and its stream path.
package buffer_pkg;

   typedef enum logic [1:0] {
      BurstIdle,
      BurstRun,
      BurstDone
   } burst_state_e;

   localparam logic ADDR_MODE_BYTE = 1'b0;
   localparam logic ADDR_MODE_WORD = 1'b1;

   // Number of byte-lane select bits within one word.
   function automatic int unsigned lane_width(input int unsigned word_bytes);
      return $clog2(word_bytes);
   endfunction

endpackage

// File: rtl/scratchpad_buffer_ctrl_stream_skid_buffer.sv
// Two-entry valid/ready FIFO feeding the burst stream; head entry drives the output.
module stream_skid_buffer #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   count
);

   logic [1:0]   count_q;
   logic [W-1:0] slot0_q, slot1_q;
   logic         pop;

   assign out_valid = (count_q != 2'd0);
   assign out_data  = slot0_q;
   assign count     = count_q;
   assign pop       = out_valid & out_ready;

   // The producer never pushes into a full buffer, so no overflow path exists.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         slot0_q <= '0;
         slot1_q <= '0;
      end else begin
         case ({in_valid, pop})
            2'b11: begin
               if (count_q == 2'd2) begin
                  slot0_q <= slot1_q;
                  slot1_q <= in_data;
               end else begin
                  slot0_q <= in_data;
               end
            end
            2'b10: begin
               if (count_q == 2'd0) slot0_q <= in_data;
               else                 slot1_q <= in_data;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               slot0_q <= slot1_q;
               count_q <= count_q - 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/scratchpad_buffer_ctrl.sv
// Single-port byte/word scratchpad with strobed writes and a strided burst-read stream engine.
module scratchpad_buffer_ctrl
   import buffer_pkg::*;
#(
   parameter int unsigned WordBytes = 8,
   parameter int unsigned BuffDepth = 256,
   parameter int unsigned ByteAddrW = $clog2(BuffDepth),
   parameter int unsigned WordAddrW = $clog2(BuffDepth / WordBytes),
   parameter int unsigned LenW      = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   write_en,
   input  logic                   read_en,
   input  logic                   addr_mode,
   input  logic [ByteAddrW-1:0]   byte_addr,
   input  logic [WordAddrW-1:0]   word_addr,
   input  logic [7:0]             byte_in,
   input  logic [8*WordBytes-1:0] word_in,
   input  logic [WordBytes-1:0]   word_strb,
   output logic [7:0]             byte_out,
   output logic [8*WordBytes-1:0] word_out,
   output logic                   rd_valid,
   input  logic                   burst_start,
   input  logic [WordAddrW-1:0]   burst_base,
   input  logic [LenW-1:0]        burst_len,
   input  logic [WordAddrW-1:0]   burst_stride,
   output logic                   burst_busy,
   output logic                   burst_done,
   output logic                   strm_valid,
   input  logic                   strm_ready,
   output logic [8*WordBytes-1:0] strm_data
);

   localparam int unsigned W     = 8 * WordBytes;
   localparam int unsigned LaneW = lane_width(WordBytes);
   localparam int unsigned Words = BuffDepth / WordBytes;

   logic [W-1:0]         mem [Words];
   logic [LaneW-1:0]     lane;
   logic [WordAddrW-1:0] byte_word_idx, acc_idx;
   logic                 direct;

   assign lane          = byte_addr[LaneW-1:0];
   assign byte_word_idx = byte_addr[ByteAddrW-1:LaneW];
   assign acc_idx       = (addr_mode == ADDR_MODE_WORD) ? word_addr : byte_word_idx;
   assign direct        = read_en | write_en;

   always_ff @(posedge clk) begin
      if (write_en) begin
         for (int i = 0; i < WordBytes; i++) begin
            if ((addr_mode == ADDR_MODE_WORD) ? word_strb[i] : (lane == LaneW'(i))) begin
               mem[acc_idx][i*8 +: 8] <= (addr_mode == ADDR_MODE_WORD) ? word_in[i*8 +: 8] : byte_in;
            end
         end
      end
   end

   logic [7:0]   byte_out_q;
   logic [W-1:0] word_out_q;
   logic         rd_valid_q;

   // Nonblocking reads of mem return pre-write data when a write shares the cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_out_q <= 8'h00;
         word_out_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= read_en;
         if (read_en) begin
            if (addr_mode == ADDR_MODE_WORD) word_out_q <= mem[word_addr];
            else                             byte_out_q <= mem[byte_word_idx][{lane, 3'b000} +: 8];
         end
      end
   end

   assign byte_out = byte_out_q;
   assign word_out = word_out_q;
   assign rd_valid = rd_valid_q;

   burst_state_e         state_q;
   logic [WordAddrW-1:0] fetch_addr_q, stride_q;
   logic [LenW-1:0]      fetch_left_q, beats_left_q;
   logic                 fetch_vld_q, busy_q, done_q;
   logic [W-1:0]         fetch_data_q;
   logic [1:0]           buf_count;
   logic [2:0]           pending;
   logic                 handshake, fetch_go;

   assign handshake = strm_valid & strm_ready;
   assign pending   = 3'(buf_count) + 3'(fetch_vld_q);
   // A beat leaving this cycle frees its slot for the fetch issued alongside it.
   assign fetch_go  = (state_q == BurstRun) && (fetch_left_q != '0) && !direct &&
                      (pending < (3'd2 + 3'(handshake)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= BurstIdle;
         fetch_addr_q <= '0;
         stride_q     <= '0;
         fetch_left_q <= '0;
         beats_left_q <= '0;
         fetch_vld_q  <= 1'b0;
         fetch_data_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         fetch_vld_q <= fetch_go;
         if (fetch_go) fetch_data_q <= mem[fetch_addr_q];
         done_q <= 1'b0;
         unique case (state_q)
            BurstIdle: begin
               if (burst_start) begin
                  busy_q       <= 1'b1;
                  fetch_addr_q <= burst_base;
                  stride_q     <= burst_stride;
                  fetch_left_q <= burst_len;
                  beats_left_q <= burst_len;
                  if (burst_len == '0) begin
                     state_q <= BurstDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= BurstRun;
                  end
               end
            end
            BurstRun: begin
               if (fetch_go) begin
                  fetch_addr_q <= fetch_addr_q + stride_q;
                  fetch_left_q <= fetch_left_q - LenW'(1);
               end
               if (handshake) begin
                  beats_left_q <= beats_left_q - LenW'(1);
                  if (beats_left_q == LenW'(1)) begin
                     state_q <= BurstDone;
                     done_q  <= 1'b1;
                  end
               end
            end
            BurstDone: begin
               state_q <= BurstIdle;
               busy_q  <= 1'b0;
            end
            default: state_q <= BurstIdle;
         endcase
      end
   end

   assign burst_busy = busy_q;
   assign burst_done = done_q;

   stream_skid_buffer #(
      .W (W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (fetch_vld_q),
      .in_data   (fetch_data_q),
      .out_valid (strm_valid),
      .out_ready (strm_ready),
      .out_data  (strm_data),
      .count     (buf_count)
   );

endmodule

// File: tb/tb_scratchpad_buffer_ctrl.sv
// Directed self-checking bench for scratchpad_buffer_ctrl (WordBytes=8, BuffDepth=256).
module tb_scratchpad_buffer_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        write_en, read_en, addr_mode;
   logic [7:0]  byte_addr;
   logic [4:0]  word_addr;
   logic [7:0]  byte_in;
   logic [63:0] word_in;
   logic [7:0]  word_strb;
   logic [7:0]  byte_out;
   logic [63:0] word_out;
   logic        rd_valid;
   logic        burst_start;
   logic [4:0]  burst_base;
   logic [7:0]  burst_len;
   logic [4:0]  burst_stride;
   logic        burst_busy, burst_done;
   logic        strm_valid, strm_ready;
   logic [63:0] strm_data;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   scratchpad_buffer_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_en     (write_en),
      .read_en      (read_en),
      .addr_mode    (addr_mode),
      .byte_addr    (byte_addr),
      .word_addr    (word_addr),
      .byte_in      (byte_in),
      .word_in      (word_in),
      .word_strb    (word_strb),
      .byte_out     (byte_out),
      .word_out     (word_out),
      .rd_valid     (rd_valid),
      .burst_start  (burst_start),
      .burst_base   (burst_base),
      .burst_len    (burst_len),
      .burst_stride (burst_stride),
      .burst_busy   (burst_busy),
      .burst_done   (burst_done),
      .strm_valid   (strm_valid),
      .strm_ready   (strm_ready),
      .strm_data    (strm_data)
   );

   function automatic logic [63:0] pat(input int i);
      return 64'h0101010101010101 * 64'(i + 1);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      write_en = 0; read_en = 0; addr_mode = 0; byte_addr = '0; word_addr = '0;
      byte_in = '0; word_in = '0; word_strb = '0; burst_start = 0; burst_base = '0;
      burst_len = '0; burst_stride = '0;
   endtask

   task automatic word_write(input logic [4:0] a, input logic [63:0] d, input logic [7:0] s);
      idle_inputs();
      write_en = 1; addr_mode = 1; word_addr = a; word_in = d; word_strb = s;
      tick();
      write_en = 0;
   endtask

   initial begin
      int hs, done_cnt, cyc;
      logic prev_stall;
      logic [63:0] prev_data, exp_d;

      idle_inputs();
      strm_ready = 0;
      rst_n = 0;
      tick(); tick();
      check("rst_byte_out", 64'(byte_out), 64'h0);
      check("rst_word_out", word_out, 64'h0);
      check("rst_rd_valid", 64'(rd_valid), 64'h0);
      check("rst_strm_valid", 64'(strm_valid), 64'h0);
      check("rst_strm_data", strm_data, 64'h0);
      check("rst_busy", 64'(burst_busy), 64'h0);
      check("rst_done", 64'(burst_done), 64'h0);
      rst_n = 1;
      tick();

      // Byte write then byte read of lane 7 of word 0.
      write_en = 1; addr_mode = 0; byte_addr = 8'd7; byte_in = 8'hFF;
      tick();
      write_en = 0; read_en = 1;
      tick();
      check("byte_rd_data", 64'(byte_out), 64'hFF);
      check("byte_rd_valid", 64'(rd_valid), 64'h1);
      read_en = 0;
      tick();
      check("rd_valid_pulse", 64'(rd_valid), 64'h0);
      read_en = 1; addr_mode = 1; word_addr = 5'd0;
      tick();
      read_en = 0;
      check("word0_top_byte", 64'(word_out[63:56]), 64'hFF);

      // Strobed word writes.
      word_write(5'd3, 64'h1122334455667788, 8'hFF);
      word_write(5'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
      read_en = 1; addr_mode = 1; word_addr = 5'd3;
      tick();
      read_en = 0;
      check("strb_merge", word_out, 64'h11223344AAAAAAAA);
      check("byte_out_held", 64'(byte_out), 64'hFF);

      // Read-first on simultaneous read and write.
      word_write(5'd1, 64'h0, 8'hFF);
      write_en = 1; read_en = 1; addr_mode = 0; byte_addr = 8'd9; byte_in = 8'h5A;
      tick();
      write_en = 0;
      check("read_first_old", 64'(byte_out), 64'h00);
      tick();
      read_en = 0;
      check("read_after_write", 64'(byte_out), 64'h5A);

      for (int i = 0; i < 32; i++) word_write(5'(i), pat(i), 8'hFF);

      // Wrapping burst at full throughput.
      idle_inputs();
      strm_ready = 1;
      burst_start = 1; burst_base = 5'd30; burst_len = 8'd4; burst_stride = 5'd1;
      tick();
      burst_start = 0;
      check("b1_busy", 64'(burst_busy), 64'h1);
      check("b1_valid_c1", 64'(strm_valid), 64'h0);
      tick();
      check("b1_valid_c2", 64'(strm_valid), 64'h0);
      tick();
      check("b1_beat0_v", 64'(strm_valid), 64'h1);
      check("b1_beat0_d", strm_data, pat(30));
      tick();
      check("b1_beat1_v", 64'(strm_valid), 64'h1);
      check("b1_beat1_d", strm_data, pat(31));
      tick();
      check("b1_beat2_v", 64'(strm_valid), 64'h1);
      check("b1_beat2_d", strm_data, pat(0));
      tick();
      check("b1_beat3_v", 64'(strm_valid), 64'h1);
      check("b1_beat3_d", strm_data, pat(1));
      check("b1_no_early_done", 64'(burst_done), 64'h0);
      tick();
      check("b1_done", 64'(burst_done), 64'h1);
      check("b1_empty", 64'(strm_valid), 64'h0);
      tick();
      check("b1_done_pulse", 64'(burst_done), 64'h0);
      check("b1_idle", 64'(burst_busy), 64'h0);

      // Strided burst under backpressure; a restart mid-burst must be ignored.
      burst_start = 1; burst_base = 5'd0; burst_len = 8'd6; burst_stride = 5'd2;
      tick();
      burst_start = 0;
      hs = 0; done_cnt = 0; prev_stall = 0; prev_data = '0;
      for (int c = 0; c < 60; c++) begin
         strm_ready = ((c % 4) == 0) || ((c % 4) == 3);
         burst_start = (c == 3);
         burst_base = 5'd20; burst_len = 8'd1; burst_stride = 5'd1;
         if (prev_stall) begin
            check("b2_hold_valid", 64'(strm_valid), 64'h1);
            check("b2_hold_data", strm_data, prev_data);
         end
         if (strm_valid) begin
            check("b2_beat_data", strm_data, pat(2 * hs));
            if (strm_ready) hs++;
         end
         if (burst_done) done_cnt++;
         prev_stall = strm_valid && !strm_ready;
         prev_data  = strm_data;
         if (done_cnt != 0 && !burst_busy) break;
         tick();
      end
      burst_start = 0;
      check("b2_handshakes", 64'(hs), 64'd6);
      check("b2_done_count", 64'(done_cnt), 64'd1);
      check("b2_idle", 64'(burst_busy), 64'h0);

      // Zero-length burst goes straight to DONE.
      burst_start = 1; burst_base = 5'd5; burst_len = 8'd0; burst_stride = 5'd1;
      tick();
      burst_start = 0;
      check("len0_busy", 64'(burst_busy), 64'h1);
      check("len0_done", 64'(burst_done), 64'h1);
      check("len0_no_beat", 64'(strm_valid), 64'h0);
      tick();
      check("len0_done_pulse", 64'(burst_done), 64'h0);
      check("len0_idle", 64'(burst_busy), 64'h0);

      // Direct writes stall fetches; the stalled fetch sees the write; reset aborts.
      strm_ready = 1;
      burst_start = 1; burst_base = 5'd4; burst_len = 8'd5; burst_stride = 5'd3;
      tick();
      idle_inputs();
      write_en = 1; addr_mode = 1; word_addr = 5'd7; word_in = 64'hDEADBEEFCAFEF00D;
      word_strb = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("b3_stalled", 64'(strm_valid), 64'h0);
      end
      write_en = 0;
      hs = 0; cyc = 0;
      while (hs < 3 && cyc < 20) begin
         if (strm_valid) begin
            exp_d = (hs == 1) ? 64'hDEADBEEFCAFEF00D : pat(4 + 3 * hs);
            check("b3_beat_data", strm_data, exp_d);
            hs++;
         end
         tick();
         cyc++;
      end
      check("b3_handshakes", 64'(hs), 64'd3);
      check("b3_still_busy", 64'(burst_busy), 64'h1);
      rst_n = 0;
      tick();
      rst_n = 1;
      check("b3_rst_valid", 64'(strm_valid), 64'h0);
      check("b3_rst_busy", 64'(burst_busy), 64'h0);
      check("b3_rst_done", 64'(burst_done), 64'h0);
      check("b3_rst_data", strm_data, 64'h0);
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (burst_done || strm_valid || burst_busy) done_cnt++;
      end
      check("b3_quiet_after_rst", 64'(done_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/scratchpad_buffer_ctrl.md
Name: scratchpad_buffer_ctrl

Overview:
Parametrised successor to the 64-bit byte/word buffer. It is a single-port scratchpad with byte and word addressing and per-byte write strobes, plus a built-in burst-read engine. The engine streams strided word sequences out over a valid/ready interface. It sits between the host load path and the accelerator datapath, feeding operand words without host micro-sequencing.

Parameters:
WordBytes, 8, bytes per word (power of two ≥2); word width W = 8*WordBytes
BuffDepth, 256, capacity in bytes (power of two, multiple of WordBytes)
ByteAddrW, $clog2(BuffDepth), byte address width (derived)
WordAddrW, $clog2(BuffDepth/WordBytes), word address width (derived)
LenW, 8, burst length counter width

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
write_en  in  1  direct write request
read_en  in  1  direct read request
addr_mode  in  1  0 = byte access, 1 = word access
byte_addr  in  ByteAddrW  byte address (addr_mode=0)
word_addr  in  WordAddrW  word address (addr_mode=1)
byte_in  in  8  byte write data
word_in  in  W  word write data
word_strb  in  WordBytes  per-byte write enable for word writes
byte_out  out  8  registered byte read data
word_out  out  W  registered word read data
rd_valid  out  1  one-cycle pulse: direct read data valid
burst_start  in  1  start burst (accepted only when idle)
burst_base  in  WordAddrW  first word address
burst_len  in  LenW  number of beats
burst_stride  in  WordAddrW  word address increment per beat
burst_busy  out  1  engine active
burst_done  out  1  one-cycle pulse after last beat handshake
strm_valid  out  1  stream data valid
strm_ready  in  1  downstream ready
strm_data  out  W  stream word

Behaviour:
- Reset (rst_n=0 at edge): byte_out=0, word_out=0, rd_valid=0, strm_valid=0, strm_data=0, burst_busy=0, burst_done=0, FSM→IDLE, output buffer emptied. Memory contents are not reset.
- Lane select: lane = byte_addr[$clog2(WordBytes)-1:0]; word index = byte_addr[ByteAddrW-1:$clog2(WordBytes)].
- Byte write: only the selected lane is updated with byte_in. Word write: lanes with word_strb[i]=1 are updated; strb=0 means no change.
- Direct read latency is 1 cycle. Byte mode updates byte_out only; word mode updates word_out only. rd_valid=1 in the following cycle. Outputs hold their value when there is no read.
- write_en and read_en in the same cycle: read-first. The read returns pre-write data and the write commits.
- Burst FSM states: IDLE, RUN, DONE.
  - IDLE: on burst_start, latch base/len/stride and go to RUN, burst_busy=1. If len=0, go to DONE instead with no beats.
  - RUN: issue word fetches at addr, addr+stride, ... Addresses wrap modulo BuffDepth/WordBytes.
  - After the last beat's strm_valid&strm_ready, go to DONE.
  - DONE lasts 1 cycle with burst_done=1, then IDLE with burst_busy=0.
- burst_start while not IDLE is ignored.
- Stream handshake: 2-entry output buffer. A fetch is issued only if fewer than 2 entries are occupied or in flight.
  - First strm_valid appears 2 cycles after start acceptance.
  - With strm_ready held at 1, throughput is 1 beat/cycle.
  - strm_data is stable while strm_valid & !strm_ready.
  - strm_valid never deasserts without a handshake.
- Arbitration: direct access (read_en or write_en) has priority for the memory port. A burst fetch is stalled that cycle and no beat is lost.
  - Fetch data reflects memory state at fetch time.
  - A direct write in the same cycle as a stalled fetch is visible to the later fetch.
- Reset mid-burst: immediate IDLE, buffer flushed, no burst_done.

Decomposition:
- Shared package (buffer_pkg): burst state enum (IDLE/RUN/DONE), ADDR_MODE_BYTE/ADDR_MODE_WORD constants, lane-width helper function.
- One natural sub-module: stream_skid_buffer (2-entry valid/ready FIFO, parameter W). The memory array and FSM stay in the top module.

Test Plan:
1. Reset, then byte-write 0xFF at byte_addr 7, then byte-read 7 → byte_out=0xFF and rd_valid=1 one cycle after read_en. Word-read word_addr 0 → word_out[63:56]=0xFF.
2. Word-write 0x1122334455667788 to word 3 with strb=0xFF, then word-write 0xAAAA… with strb=0x0F → word_out=0x11223344AAAAAAAA.
3. Same-cycle write 0x5A and read at byte 9 (old value 0x00) → byte_out=0x00; next read returns 0x5A.
4. Burst base=30, len=4, stride=1, strm_ready=1 (32 words) → beats from words 30, 31, 0, 1 on consecutive cycles starting 2 cycles after start; burst_done pulses once after beat 4.
5. Burst len=6, stride=2, strm_ready toggled 1,0,0,1,… → strm_data held while stalled; exactly 6 handshakes in order 0,2,4,6,8,10; a second burst_start during RUN is ignored.
6. Direct writes every cycle during a burst, then rst_n=0 mid-burst → fetches delayed with no beat lost; after reset strm_valid=0, burst_busy=0, no burst_done.
